// File: rtl/smartcargo_serial_tx.sv
`timescale 1ns/1ps
// smartcargo_serial_tx: 8N1 UART transmitter with a small byte FIFO in front.
// Status bytes enter through a valid/ready handshake and leave LSB first on TX.
module smartcargo_serial_tx #(
  parameter int BIT_CYCLES = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  dados,
  input  logic                        envia,
  output logic                        pronto,
  output logic                        TX,
  output logic                        ocupado,
  output logic [$clog2(FIFO_DEPTH):0] fifo_nivel,
  output logic                        descartado
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic          fifo_empty;

  // Full means full: a pop in the same cycle does not open a slot for a push.
  assign pronto     = (fifo_nivel != LEVEL_FULL);
  assign fifo_empty = (fifo_nivel == '0);
  assign push       = envia && pronto;
  assign bit_end    = (bit_cnt == BIT_LAST);
  assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
  assign ocupado    = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= dados;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_nivel <= '0;
      descartado <= 1'b0;
    end else begin
      descartado <= envia && !pronto;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_nivel <= fifo_nivel + 1'b1;
        2'b01:   fifo_nivel <= fifo_nivel - 1'b1;
        default: ;
      endcase
    end
  end

  // TX is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TX      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          TX      <= 1'b1;
          bit_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          TX <= 1'b0;
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          TX <= shift[0];
          if (bit_end) begin
            bit_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          TX <= 1'b1;
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/smartcargo_serial_tx.md
# smartcargo_serial_tx

UART transmitter for the SmartCargo elevator controller, the outbound counterpart of the serial command receiver on `RX`. Status bytes from the controller (current floor, cargo object and destination, emergency flags) are queued in a small FIFO through a valid/ready handshake. They are sent on `TX` as 8N1 frames, LSB first, at 115200 baud from the 50 MHz system clock. The block sits between the main control FSM and the board's serial output pin.

## Interface
- `BIT_CYCLES`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range 2..65535.
- `FIFO_DEPTH`, default 4: number of queued bytes. Must be a power of 2, at least 2.
- `clock` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: reset, asynchronous and active-low.
- `dados` input 8: byte to transmit.
- `envia` input 1: producer valid. Sampled on the rising edge.
- `pronto` output 1: ready. High when the FIFO is not full.
- `TX` output 1: serial line. Idles high.
- `ocupado` output 1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_nivel` output log2(FIFO_DEPTH)+1: number of bytes currently queued. Excludes the byte in flight.
- `descartado` output 1: one-cycle pulse when `envia` is high while `pronto` is low.

## Operation
- Handshake: a byte is accepted on a rising edge where `envia && pronto`. It is written to the FIFO tail.
- `envia` with `pronto` low: the byte is dropped and FIFO state is unchanged. `descartado` is high for the following cycle.
- `pronto` is combinational from the current level: `fifo_nivel != FIFO_DEPTH`. A pop in the same cycle does not make room for a push while the FIFO is full.
- Push and pop in the same cycle when the FIFO is neither full nor empty: `fifo_nivel` is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- FSM states:
  - IDLE: `TX`=1. If the FIFO is non-empty, pop the head into the shift register, go to START, clear the bit counter.
  - START: `TX`=0 for BIT_CYCLES cycles, then DATA with bit index 0.
  - DATA: `TX`=shift[0] for BIT_CYCLES cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `TX`=1 for BIT_CYCLES cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back, no extra idle). Otherwise go to IDLE.
- Bit counter: 0..BIT_CYCLES-1, 16 bits, reset to 0 on every bit boundary.
- `TX` is driven from a register, so it is glitch-free.
- `ocupado` = (state != IDLE) || (fifo_nivel != 0).

## Timing
- Reset values: `TX`=1, `pronto`=1, `ocupado`=0, `fifo_nivel`=0, `descartado`=0, state IDLE, FIFO empty.
- Reset asserted mid-frame: `TX` returns to 1 immediately (asynchronously) and all queued bytes are lost.
- Latency, idle block: byte accepted at edge N. FSM pops at edge N+1. `TX` falls after edge N+2.
- Frame length: exactly 10·BIT_CYCLES cycles, from the `TX` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the first cycle after the stop bit's BIT_CYCLES-th cycle.
- `fifo_nivel` decrements at the pop edge, i.e. when the frame enters START.
- `pronto` can rise in the same cycle as that pop.
- `descartado` is registered and high for exactly one cycle per rejected beat.

## Test plan
- Reset, then one push of 0x1C: `TX` falls 2 cycles after acceptance. The line then reads 0,0,0,1,1,1,0,0,0,1 (start, LSB-first data, stop), each bit 434 cycles. `ocupado` drops after 4340 cycles.
- Push 0x1C and 0x1E on consecutive cycles: two frames with zero idle cycles between the stop bit and the second start bit. `fifo_nivel` sequence is 1, then 0 at pop, and so on.
- With the FSM busy, push 5 bytes (one in flight plus 4 queued): the 5th is accepted. A 6th push with `pronto`=0 pulses `descartado` and does not change `fifo_nivel`=4. All 5 bytes are transmitted in order.
- Fill the FIFO to full, and assert `envia` on the very cycle the FSM pops: the byte is rejected (`descartado`=1). On the next cycle `pronto`=1.
- Pulse `reset` low mid-DATA of byte 0xA5 with 2 bytes queued: `TX`=1 immediately, `fifo_nivel`=0, `ocupado`=0. After release, no frame is sent until a new push.
- With BIT_CYCLES=4, send 0xFF then 0x00: each bit lasts 4 cycles and each frame is 40 cycles.
